layer_tile_sequencer: RTL and testbench

LAYER_TILE_SEQUENCER -- requirements
Module: layer_tile_sequencer

---
 rtl/cnn_pkg.sv | 63 ++++++
 rtl/tile_addr_gen.sv | 69 ++++++
 rtl/layer_tile_sequencer.sv | 228 ++++++++++++++++++++++
 tb/tb_layer_tile_sequencer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// -----------------------------------------------------------------------------
// cnn_pkg
// Shared definitions for the CNN layer sequencing logic: configuration field
// widths, the default PE-array width, the tile sequencer state encoding and
// small arithmetic helpers used by the sequencer and its address generator.
// No ports (package).
// -----------------------------------------------------------------------------
package cnn_pkg;

    // Filters computed per PE-array pass (default).
    localparam int PE_COLS_DEF  = 16;

    // Layer configuration field widths.
    localparam int IFM_SIZE_W   = 9;
    localparam int CH_W         = 11;
    localparam int KSZ_W        = 2;
    localparam int MP_STRIDE_W  = 2;

    // Filters in one group; PE_COLS must therefore not exceed 31.
    localparam int GF_W         = 5;

    // One OFM plane is ofm_dim*ofm_dim.
    localparam int PLANE_W      = 2 * IFM_SIZE_W;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD_W  = 3'd1,
        ST_COMPUTE = 3'd2,
        ST_WRBACK  = 3'd3,
        ST_NEXT    = 3'd4,
        ST_DONE    = 3'd5
    } seq_state_t;

    // Output feature-map edge: halved only for a stride-2 max-pool.
    function automatic logic [IFM_SIZE_W-1:0] ofm_dim_f(
        input logic [IFM_SIZE_W-1:0]  ifm_size,
        input logic                   mp_mode,
        input logic [MP_STRIDE_W-1:0] mp_stride
    );
        logic [IFM_SIZE_W-1:0] dim;
        if (mp_mode && (mp_stride == 2'd2)) begin
            dim = ifm_size >> 1'b1;
        end else begin
            dim = ifm_size;
        end
        return dim;
    endfunction

    // Filters in the next group: a full PE row, or whatever is left over.
    function automatic logic [GF_W-1:0] group_size_f(
        input logic [CH_W-1:0] rem,
        input logic [GF_W-1:0] pe_cols
    );
        logic [GF_W-1:0] gs;
        if (rem >= {{(CH_W-GF_W){1'b0}}, pe_cols}) begin
            gs = pe_cols;
        end else begin
            gs = rem[GF_W-1:0];
        end
        return gs;
    endfunction

endpackage

// File: rtl/tile_addr_gen.sv
// -----------------------------------------------------------------------------
// tile_addr_gen
// Write-address generator for the tile sequencer. Captures the spatial layer
// configuration when a layer is accepted, derives the OFM plane size and
// advances the OFM write address by plane*group_filters once per group.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   load              layer accepted: capture geometry, restart at base_addr
//   advance           end of a group: step past the group just written
//   ifm_size          input feature-map edge length
//   maxpool_mode      max-pool enabled
//   maxpool_stride    max-pool stride
//   base_addr         layer OFM base address
//   group_filters     filters in the group just written
//   write_addr        current group OFM write address (registered)
// -----------------------------------------------------------------------------
module tile_addr_gen
    import cnn_pkg::*;
#(
    parameter int ADDR_W = 22
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic                   advance,
    input  logic [IFM_SIZE_W-1:0]  ifm_size,
    input  logic                   maxpool_mode,
    input  logic [MP_STRIDE_W-1:0] maxpool_stride,
    input  logic [ADDR_W-1:0]      base_addr,
    input  logic [GF_W-1:0]        group_filters,
    output logic [ADDR_W-1:0]      write_addr
);

    localparam int INCR_W = PLANE_W + GF_W;

    logic [IFM_SIZE_W-1:0] ofm_dim_r;
    logic [ADDR_W-1:0]     waddr_r;
    logic [PLANE_W-1:0]    plane_s;
    logic [INCR_W-1:0]     incr_s;
    logic [ADDR_W-1:0]     incr_addr_s;

    // Plane size and per-group address step; the step wraps modulo 2^ADDR_W.
    always_comb begin
        plane_s     = {{IFM_SIZE_W{1'b0}}, ofm_dim_r} * {{IFM_SIZE_W{1'b0}}, ofm_dim_r};
        incr_s      = {{GF_W{1'b0}}, plane_s} * {{PLANE_W{1'b0}}, group_filters};
        incr_addr_s = ADDR_W'(incr_s);
    end

    // Geometry capture and write-address accumulator.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ofm_dim_r <= {IFM_SIZE_W{1'b0}};
            waddr_r   <= {ADDR_W{1'b0}};
        end else if (load) begin
            ofm_dim_r <= ofm_dim_f(ifm_size, maxpool_mode, maxpool_stride);
            waddr_r   <= base_addr;
        end else if (advance) begin
            ofm_dim_r <= ofm_dim_r;
            waddr_r   <= waddr_r + incr_addr_s;
        end else begin
            ofm_dim_r <= ofm_dim_r;
            waddr_r   <= waddr_r;
        end
    end

    assign write_addr = waddr_r;

endmodule

// File: rtl/layer_tile_sequencer.sv
// -----------------------------------------------------------------------------
// layer_tile_sequencer
// Walks one CNN layer through filter groups of up to PE_COLS filters. For each
// group it requests a weight load, starts a PE-array pass, then starts the OFM
// write-back, handshaking each step with a one-cycle start pulse and a
// one-cycle done pulse. Configuration is captured when start_layer is accepted
// and held for the whole layer.
//
// Optional build feature (macro TILE_SEQ_PERF_EN): adds output stall_cycles,
// counting busy cycles spent in LOAD_W or WRBACK, cleared on layer start.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   start_layer                  one-cycle pulse, accepted only while idle
//   ifm_size .. maxpool_stride   layer configuration
//   start_read_addr              IFM base address (held for all groups)
//   start_write_addr             OFM base address of group 0
//   wload_start / wload_done     weight-load handshake
//   comp_start / comp_done       PE-array pass handshake
//   wb_start / wb_done           OFM write-back handshake
//   group_filters                filters in the current group
//   tile_read_addr               current IFM read address
//   tile_write_addr              current OFM write address
//   busy                         high from acceptance through done_layer
//   done_layer                   one-cycle pulse when the layer finishes
//   stall_cycles                 (TILE_SEQ_PERF_EN only) stall counter
// -----------------------------------------------------------------------------
module layer_tile_sequencer
    import cnn_pkg::*;
#(
    parameter int PE_COLS = PE_COLS_DEF,
    parameter int ADDR_W  = 22
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_layer,
    input  logic [IFM_SIZE_W-1:0]  ifm_size,
    input  logic [CH_W-1:0]        ifm_channel,
    input  logic [CH_W-1:0]        num_filter,
    input  logic [KSZ_W-1:0]       kernel_size,
    input  logic                   maxpool_mode,
    input  logic [MP_STRIDE_W-1:0] maxpool_stride,
    input  logic [ADDR_W-1:0]      start_read_addr,
    input  logic [ADDR_W-1:0]      start_write_addr,
    output logic                   wload_start,
    input  logic                   wload_done,
    output logic                   comp_start,
    input  logic                   comp_done,
    output logic                   wb_start,
    input  logic                   wb_done,
    output logic [GF_W-1:0]        group_filters,
    output logic [ADDR_W-1:0]      tile_read_addr,
    output logic [ADDR_W-1:0]      tile_write_addr,
    output logic                   busy,
    output logic                   done_layer
`ifdef TILE_SEQ_PERF_EN
    ,
    output logic [31:0]            stall_cycles
`endif
);

    localparam logic [GF_W-1:0] PE_COLS_V = GF_W'(PE_COLS);

    seq_state_t              state_r;
    logic                    wload_start_r;
    logic                    comp_start_r;
    logic                    wb_start_r;
    logic                    done_layer_r;
    logic                    busy_r;
    logic [CH_W-1:0]         rem_r;
    logic [GF_W-1:0]         group_filters_r;
    logic [ADDR_W-1:0]       rd_addr_r;
    // Channel count and kernel size are held with the layer but are consumed
    // by the PE array, not by this sequencer.
    logic [CH_W+KSZ_W-1:0]   cfg_unused_r;

    logic                    accept_s;
    logic                    advance_s;
    logic [CH_W-1:0]         rem_next_s;

    // Layer acceptance, group-advance strobe and remaining-filter update.
    always_comb begin
        accept_s   = 1'b0;
        advance_s  = 1'b0;
        rem_next_s = rem_r - {{(CH_W-GF_W){1'b0}}, group_filters_r};
        if ((state_r == ST_IDLE) && !busy_r && start_layer) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
        if (state_r == ST_NEXT) begin
            advance_s = 1'b1;
        end else begin
            advance_s = 1'b0;
        end
    end

    // Sequencer FSM with registered handshake pulses and status.
    // done_layer is issued on the edge leaving DONE, so busy stays high for
    // the done_layer cycle and drops on the cycle after it; start_layer is
    // ignored throughout because acceptance also requires busy low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r         <= ST_IDLE;
            wload_start_r   <= 1'b0;
            comp_start_r    <= 1'b0;
            wb_start_r      <= 1'b0;
            done_layer_r    <= 1'b0;
            busy_r          <= 1'b0;
            rem_r           <= {CH_W{1'b0}};
            group_filters_r <= {GF_W{1'b0}};
            rd_addr_r       <= {ADDR_W{1'b0}};
            cfg_unused_r    <= {(CH_W+KSZ_W){1'b0}};
        end else begin
            wload_start_r <= 1'b0;
            comp_start_r  <= 1'b0;
            wb_start_r    <= 1'b0;
            done_layer_r  <= 1'b0;
            if (done_layer_r) begin
                busy_r <= 1'b0;
            end else begin
                busy_r <= busy_r;
            end
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        busy_r          <= 1'b1;
                        rem_r           <= num_filter;
                        group_filters_r <= group_size_f(num_filter, PE_COLS_V);
                        rd_addr_r       <= start_read_addr;
                        cfg_unused_r    <= {ifm_channel, kernel_size};
                        if (num_filter == {CH_W{1'b0}}) begin
                            state_r <= ST_DONE;
                        end else begin
                            state_r       <= ST_LOAD_W;
                            wload_start_r <= 1'b1;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_LOAD_W: begin
                    if (wload_done) begin
                        state_r      <= ST_COMPUTE;
                        comp_start_r <= 1'b1;
                    end else begin
                        state_r <= ST_LOAD_W;
                    end
                end
                ST_COMPUTE: begin
                    if (comp_done) begin
                        state_r    <= ST_WRBACK;
                        wb_start_r <= 1'b1;
                    end else begin
                        state_r <= ST_COMPUTE;
                    end
                end
                ST_WRBACK: begin
                    if (wb_done) begin
                        state_r <= ST_NEXT;
                    end else begin
                        state_r <= ST_WRBACK;
                    end
                end
                ST_NEXT: begin
                    rem_r           <= rem_next_s;
                    group_filters_r <= group_size_f(rem_next_s, PE_COLS_V);
                    if (rem_next_s == {CH_W{1'b0}}) begin
                        state_r <= ST_DONE;
                    end else begin
                        state_r       <= ST_LOAD_W;
                        wload_start_r <= 1'b1;
                    end
                end
                ST_DONE: begin
                    done_layer_r <= 1'b1;
                    state_r      <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    tile_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk            (clk),
        .rst            (rst),
        .load           (accept_s),
        .advance        (advance_s),
        .ifm_size       (ifm_size),
        .maxpool_mode   (maxpool_mode),
        .maxpool_stride (maxpool_stride),
        .base_addr      (start_write_addr),
        .group_filters  (group_filters_r),
        .write_addr     (tile_write_addr)
    );

`ifdef TILE_SEQ_PERF_EN
    logic [31:0] stall_cnt_r;

    // Busy cycles spent waiting on the weight loader or the write-back.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_r <= 32'd0;
        end else if (accept_s) begin
            stall_cnt_r <= 32'd0;
        end else if (busy_r && ((state_r == ST_LOAD_W) || (state_r == ST_WRBACK))) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_cycles = stall_cnt_r;
`endif

    assign wload_start    = wload_start_r;
    assign comp_start     = comp_start_r;
    assign wb_start       = wb_start_r;
    assign done_layer     = done_layer_r;
    assign busy           = busy_r;
    assign group_filters  = group_filters_r;
    assign tile_read_addr = rd_addr_r;

endmodule

// File: tb/tb_layer_tile_sequencer.sv
// -----------------------------------------------------------------------------
// tb_layer_tile_sequencer
// Directed bench for layer_tile_sequencer (PE_COLS=16, ADDR_W=22). The bench
// plays the weight loader, PE array and write-back engine, and compares the
// sequencer outputs against hand-computed values.
// -----------------------------------------------------------------------------
module tb_layer_tile_sequencer;

    logic        clk;
    logic        rst;
    logic        start_layer;
    logic [8:0]  ifm_size;
    logic [10:0] ifm_channel;
    logic [10:0] num_filter;
    logic [1:0]  kernel_size;
    logic        maxpool_mode;
    logic [1:0]  maxpool_stride;
    logic [21:0] start_read_addr;
    logic [21:0] start_write_addr;
    logic        wload_start;
    logic        wload_done;
    logic        comp_start;
    logic        comp_done;
    logic        wb_start;
    logic        wb_done;
    logic [4:0]  group_filters;
    logic [21:0] tile_read_addr;
    logic [21:0] tile_write_addr;
    logic        busy;
    logic        done_layer;
`ifdef TILE_SEQ_PERF_EN
    logic [31:0] stall_cycles;
`endif

    int n_checks;
    int n_pass;
    int n_wl;
    int n_cs;
    int n_wb;
    int n_dn;
    int exp_rd;

    layer_tile_sequencer #(
        .PE_COLS (16),
        .ADDR_W  (22)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .start_layer      (start_layer),
        .ifm_size         (ifm_size),
        .ifm_channel      (ifm_channel),
        .num_filter       (num_filter),
        .kernel_size      (kernel_size),
        .maxpool_mode     (maxpool_mode),
        .maxpool_stride   (maxpool_stride),
        .start_read_addr  (start_read_addr),
        .start_write_addr (start_write_addr),
        .wload_start      (wload_start),
        .wload_done       (wload_done),
        .comp_start       (comp_start),
        .comp_done        (comp_done),
        .wb_start         (wb_start),
        .wb_done          (wb_done),
        .group_filters    (group_filters),
        .tile_read_addr   (tile_read_addr),
        .tile_write_addr  (tile_write_addr),
        .busy             (busy),
        .done_layer       (done_layer)
`ifdef TILE_SEQ_PERF_EN
        ,
        .stall_cycles     (stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters for the handshake outputs.
    always @(posedge clk) begin
        if (wload_start) n_wl <= n_wl + 1;
        if (comp_start)  n_cs <= n_cs + 1;
        if (wb_start)    n_wb <= n_wb + 1;
        if (done_layer)  n_dn <= n_dn + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int nf, input int isz, input bit mpm, input int mps,
                           input int rd, input int wr);
        num_filter       = 11'(nf);
        ifm_size         = 9'(isz);
        maxpool_mode     = mpm;
        maxpool_stride   = 2'(mps);
        start_read_addr  = 22'(rd);
        start_write_addr = 22'(wr);
        ifm_channel      = 11'd3;
        kernel_size      = 2'd3;
        exp_rd           = rd;
    endtask

    // Entered on the first cycle of LOAD_W; leaves after the next LOAD_W
    // entry or, for the last group, after busy has dropped.
    task automatic run_group(input string tag, input int gf, input int waddr,
                             input bit last, input bit inject);
        check({tag, "_wload_start"}, wload_start, 1);
        check({tag, "_gf"}, group_filters, gf);
        check({tag, "_waddr"}, tile_write_addr, waddr);
        check({tag, "_raddr"}, tile_read_addr, exp_rd);
        step();
        check({tag, "_wload_pulse_len"}, wload_start, 0);
        if (inject) begin
            comp_done = 1'b1;
            step();
            comp_done = 1'b0;
            check({tag, "_stray_comp_done"}, comp_start, 0);
            check({tag, "_stray_wb"}, wb_start, 0);
        end
        wload_done = 1'b1;
        step();
        wload_done = 1'b0;
        check({tag, "_comp_start"}, comp_start, 1);
        if (inject) begin
            start_layer = 1'b1;
            num_filter  = 11'd0;
            step();
            start_layer = 1'b0;
            check({tag, "_restart_ignored_busy"}, busy, 1);
            check({tag, "_restart_ignored_gf"}, group_filters, gf);
            check({tag, "_restart_no_wload"}, wload_start, 0);
        end
        comp_done = 1'b1;
        step();
        comp_done = 1'b0;
        check({tag, "_wb_start"}, wb_start, 1);
        wb_done = 1'b1;
        step();
        wb_done = 1'b0;
        step();
        if (last) begin
            check({tag, "_no_more_wload"}, wload_start, 0);
            check({tag, "_done_early"}, done_layer, 0);
            step();
            check({tag, "_done_layer"}, done_layer, 1);
            check({tag, "_busy_in_done"}, busy, 1);
            step();
            check({tag, "_done_len"}, done_layer, 0);
            check({tag, "_busy_low"}, busy, 0);
        end
    endtask

    initial begin
        int wl0, cs0, wb0, dn0;
        n_checks = 0; n_pass = 0;
        n_wl = 0; n_cs = 0; n_wb = 0; n_dn = 0;
        rst = 1'b1; start_layer = 1'b0;
        wload_done = 1'b0; comp_done = 1'b0; wb_done = 1'b0;
        set_cfg(0, 0, 1'b0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_wload", wload_start, 0);
        check("rst_done", done_layer, 0);
        check("rst_waddr", tile_write_addr, 0);
        check("rst_gf", group_filters, 0);
        rst = 1'b0;
        step();

        // Two groups of 16, 62x62 pooled to 31x31: step 961*16 = 15376.
        wl0 = n_wl; cs0 = n_cs; wb0 = n_wb; dn0 = n_dn;
        set_cfg(32, 62, 1'b1, 2, 1000, 61504);
        start_layer = 1'b1;
        step();
        start_layer = 1'b0;
        check("A_busy", busy, 1);
        run_group("A0", 16, 61504, 1'b0, 1'b0);
        run_group("A1", 16, 76880, 1'b1, 1'b0);
        check("A_n_wload", n_wl - wl0, 2);
        check("A_n_done", n_dn - dn0, 1);

        // 255 filters on 13x13: 16 groups, step 16*169 = 2704, last group 15.
        // A wload_done coincident with the start must be ignored.
        wl0 = n_wl;
        set_cfg(255, 13, 1'b0, 2, 5, 100);
        start_layer = 1'b1;
        wload_done  = 1'b1;
        step();
        start_layer = 1'b0;
        wload_done  = 1'b0;
        for (int g = 0; g < 16; g++) begin
            run_group($sformatf("B%0d", g), (g == 15) ? 15 : 16, 100 + g * 2704,
                      (g == 15), 1'b0);
        end
        check("B_final_waddr", tile_write_addr, 100 + 255 * 169);
        check("B_n_wload", n_wl - wl0, 16);

        // No filters: straight to DONE, done_layer two cycles after start.
        wl0 = n_wl; cs0 = n_cs; wb0 = n_wb; dn0 = n_dn;
        set_cfg(0, 20, 1'b0, 0, 7, 300);
        start_layer = 1'b1;
        step();
        start_layer = 1'b0;
        check("C_busy", busy, 1);
        check("C_done_cycle1", done_layer, 0);
        step();
        check("C_done_cycle2", done_layer, 1);
        step();
        check("C_busy_low", busy, 0);
        check("C_no_wload", n_wl - wl0, 0);
        check("C_no_comp", n_cs - cs0, 0);
        check("C_no_wb", n_wb - wb0, 0);
        check("C_n_done", n_dn - dn0, 1);

        // Stray comp_done in LOAD_W and re-pulsed start_layer in COMPUTE.
        dn0 = n_dn;
        set_cfg(32, 62, 1'b1, 2, 1000, 61504);
        start_layer = 1'b1;
        step();
        start_layer = 1'b0;
        run_group("D0", 16, 61504, 1'b0, 1'b1);
        run_group("D1", 16, 76880, 1'b1, 1'b0);
        check("D_n_done", n_dn - dn0, 1);

        // Reset during WRBACK of group 1, then a clean rerun.
        set_cfg(32, 62, 1'b1, 2, 1000, 61504);
        start_layer = 1'b1;
        step();
        start_layer = 1'b0;
        run_group("E0", 16, 61504, 1'b0, 1'b0);
        check("E1_wload_start", wload_start, 1);
        wload_done = 1'b1;
        step();
        wload_done = 1'b0;
        comp_done = 1'b1;
        step();
        comp_done = 1'b0;
        check("E1_wb_start", wb_start, 1);
        step();
        rst = 1'b1;
        #2;
        check("E_rst_busy", busy, 0);
        check("E_rst_waddr", tile_write_addr, 0);
        check("E_rst_raddr", tile_read_addr, 0);
        check("E_rst_gf", group_filters, 0);
        check("E_rst_wb", wb_start, 0);
        step();
        rst = 1'b0;
        check("E_idle_done", done_layer, 0);
        step();
        dn0 = n_dn;
        start_layer = 1'b1;
        step();
        start_layer = 1'b0;
        run_group("F0", 16, 61504, 1'b0, 1'b0);
        run_group("F1", 16, 76880, 1'b1, 1'b0);
        check("F_n_done", n_dn - dn0, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
